median_window_3x3: RTL and testbench

- Builds the 3x3 pixel neighbourhood feeding the median sorter stage.
- Consumes a raster pixel stream and stores the two previous image lines in two sync_fifo line buffers.
- Emits one packed 3x3 window per valid interior position, so the output image is (IMG_W-2)x(IMG_H-2).
- Sits between the pixel input adapter and the median sorter.

---
 rtl/median_window_3x3_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/median_window_3x3.sv | 136 +++++++++++++
 tb/tb_median_window_3x3.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/median_window_3x3_pkg.sv
// Shared definitions for the 3x3 median window builder: tap layout, control states
// and counter sizing.
package median_window_3x3_pkg;

  localparam int WIN_TAPS = 9;

  // Tap index k = 3*row + col inside the packed window (row 0 = oldest line).
  localparam int TL = 0;
  localparam int TC = 1;
  localparam int TR = 2;
  localparam int ML = 3;
  localparam int MC = 4;
  localparam int MR = 5;
  localparam int BL = 6;
  localparam int BC = 7;
  localparam int BR = 8;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Bits needed to count 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: dout presents the head word whenever !empty and
// rd_en pops it.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 2048,
  parameter int USE_VENDOR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The vendor flavour steers storage toward dedicated RAM; the default uses fabric memory.
  generate
    if (USE_VENDOR != 0) begin : g_vendor
      (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
      end
      assign dout = mem[rd_ptr];
    end else begin : g_fabric
      (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
      end
      assign dout = mem[rd_ptr];
    end
  endgenerate

endmodule

// File: rtl/median_window_3x3.sv
// Builds 3x3 neighbourhoods from a raster pixel stream using two line FIFOs and
// presents one packed window per interior pixel to the median sorter.
module median_window_3x3
  import median_window_3x3_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int DEPTH      = 2048,
  parameter int USE_VENDOR = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          s_data,
  input  logic                      s_valid,
  input  logic                      s_sof,
  output logic                      s_ready,
  output logic [WIN_TAPS*WIDTH-1:0] m_win,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  state_t                      state;
  logic [RW-1:0]               row;
  logic [CW-1:0]               col;
  logic [WIN_TAPS*WIDTH-1:0]   taps_p0;
  logic [WIN_TAPS*WIDTH-1:0]   taps_nxt;
  logic [WIDTH-1:0]            top_px;
  logic [WIDTH-1:0]            mid_px;
  logic [WIDTH-1:0]            f0_dout;
  logic [WIDTH-1:0]            f1_dout;
  logic                        f0_wr, f0_rd, f0_full, f0_empty;
  logic                        f1_wr, f1_rd, f1_full, f1_empty;
  logic                        slot_free, at_origin, early_sof, accept;
  logic                        row_ge1, row_ge2, win_ok;

  assign slot_free = !m_valid || m_ready;
  assign at_origin = (row == '0) && (col == '0);
  assign early_sof = s_valid && s_sof && !at_origin;
  assign s_ready   = (state == RUN) && slot_free && !early_sof;
  assign accept    = s_valid && s_ready;

  assign row_ge1 = (row != '0);
  assign row_ge2 = (row > ROW_ONE);
  assign win_ok  = row_ge2 && (col > COL_ONE);

  // FIFO0 carries line row-1, FIFO1 carries line row-2; the last line feeds neither.
  assign f0_wr = accept && (row != ROW_LAST);
  assign f1_wr = accept && row_ge1 && (row != ROW_LAST);
  assign f0_rd = (state == FLUSH) ? !f0_empty : (accept && row_ge1);
  assign f1_rd = (state == FLUSH) ? !f1_empty : (accept && row_ge2);

  assign top_px = row_ge2 ? f1_dout : '0;
  assign mid_px = row_ge1 ? f0_dout : '0;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .USE_VENDOR(USE_VENDOR)) u_line0 (
    .clk(clk), .rst(rst), .wr_en(f0_wr), .din(s_data), .rd_en(f0_rd),
    .dout(f0_dout), .full(f0_full), .empty(f0_empty)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .USE_VENDOR(USE_VENDOR)) u_line1 (
    .clk(clk), .rst(rst), .wr_en(f1_wr), .din(f0_dout), .rd_en(f1_rd),
    .dout(f1_dout), .full(f1_full), .empty(f1_empty)
  );

  always_comb begin
    taps_nxt = taps_p0;
    taps_nxt[TL*WIDTH +: WIDTH] = taps_p0[TC*WIDTH +: WIDTH];
    taps_nxt[TC*WIDTH +: WIDTH] = taps_p0[TR*WIDTH +: WIDTH];
    taps_nxt[TR*WIDTH +: WIDTH] = top_px;
    taps_nxt[ML*WIDTH +: WIDTH] = taps_p0[MC*WIDTH +: WIDTH];
    taps_nxt[MC*WIDTH +: WIDTH] = taps_p0[MR*WIDTH +: WIDTH];
    taps_nxt[MR*WIDTH +: WIDTH] = mid_px;
    taps_nxt[BL*WIDTH +: WIDTH] = taps_p0[BC*WIDTH +: WIDTH];
    taps_nxt[BC*WIDTH +: WIDTH] = taps_p0[BR*WIDTH +: WIDTH];
    taps_nxt[BR*WIDTH +: WIDTH] = s_data;
  end

  // p0: tap shift, raster counters, control state and the registered output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      row     <= '0;
      col     <= '0;
      taps_p0 <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_win   <= '0;
    end else begin
      if (accept && win_ok) begin
        m_valid <= 1'b1;
        m_win   <= taps_nxt;
        m_last  <= (row == ROW_LAST) && (col == COL_LAST);
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      case (state)
        RUN: begin
          if (early_sof) begin
            state <= FLUSH;
          end else if (accept) begin
            taps_p0 <= taps_nxt;
            if (col == COL_LAST) begin
              col <= '0;
              row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        FLUSH: begin
          row     <= '0;
          col     <= '0;
          taps_p0 <= '0;
          if (f0_empty && f1_empty) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // The line FIFOs are sized so that RUN never pushes into a full or pops an empty FIFO.
  a_line_fifo_safe: assert property (@(posedge clk) disable iff (rst)
    !(f0_wr && f0_full) && !(f1_wr && f1_full) && !(f0_rd && f0_empty) && !(f1_rd && f1_empty));

endmodule

// File: tb/tb_median_window_3x3.sv
// Scoreboard bench for median_window_3x3: stimulus pushes expected windows from a
// frame-array reference model, a negedge monitor pops and compares them.
module tb_median_window_3x3;

  localparam int W   = 8;
  localparam int IW  = 8;
  localparam int IH  = 6;
  localparam int DEP = 16;
  localparam int WB  = 9 * W;
  localparam int NPIX = IW * IH;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  s_data;
  logic          s_valid, s_sof, s_ready;
  logic [WB-1:0] m_win;
  logic          m_valid, m_last, m_ready;

  always #5 clk = ~clk;

  median_window_3x3 #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH), .DEPTH(DEP), .USE_VENDOR(0)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
    .s_ready(s_ready), .m_win(m_win), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
  );

  typedef struct {
    logic [WB-1:0] win;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  int            checks = 0;
  int            errors = 0;
  int            viol = 0;
  logic [W-1:0]  img [IH][IW];
  int            mr = 0;
  int            mc = 0;
  bit            hold = 0;
  bit            rnd_ready = 0;
  bit            prev_stall = 0;
  logic [WB-1:0] prev_win;
  logic          prev_last;
  logic [WB-1:0] first_win;

  task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: the frame is kept as a 2-D array and each window read straight out of it.
  task automatic model_accept(input logic [W-1:0] d, input logic sof);
    exp_t x;
    if (sof) begin mr = 0; mc = 0; end
    img[mr][mc] = d;
    if (mr >= 2 && mc >= 2) begin
      for (int k = 0; k < 9; k++) x.win[k*W +: W] = img[mr - 2 + k / 3][mc - 2 + k % 3];
      x.last = (mr == IH - 1) && (mc == IW - 1);
      exp_q.push_back(x);
    end
    mc++;
    if (mc == IW) begin
      mc = 0;
      mr++;
      if (mr == IH) mr = 0;
    end
  endtask

  task automatic send_pixel(input logic [W-1:0] d, input logic sof, input bit gaps, input bit blocked);
    bit acc;
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    s_data = d; s_sof = sof; s_valid = 1'b1;
    acc = 0; n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (n == 0 && blocked) check("early_sof_s_ready", WB'(s_ready), WB'(0));
      acc = s_ready;
      if (acc && blocked) check("flush_fifos_empty", WB'({dut.f0_empty, dut.f1_empty}), WB'(2'b11));
      @(posedge clk); #1;
      n++;
    end
    s_valid = 1'b0; s_sof = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: pixel %h not accepted after %0d cycles", d, n);
    end else begin
      model_accept(d, sof);
    end
  endtask

  task automatic send_range(input bit rand_data, input int first, input int last_excl, input bit gaps);
    int r, c;
    logic [W-1:0] d;
    for (int i = first; i < last_excl; i++) begin
      r = i / IW;
      c = i % IW;
      d = rand_data ? W'($urandom_range(0, 255)) : W'(16 * r + c);
      send_pixel(d, (i == 0) && !rand_data, gaps, 1'b0);
    end
  endtask

  task automatic fifo_empty_chk(input string name);
    check(name, WB'({dut.f0_empty, dut.f1_empty}), WB'(2'b11));
  endtask

  task automatic first_window_chk();
    check("first_valid", WB'(m_valid), WB'(1));
    check("first_win", m_win, first_win);
  endtask

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      m_ready = hold ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", WB'(m_valid), WB'(1));
          check("stall_win", m_win, prev_win);
          check("stall_last", WB'(m_last), WB'(prev_last));
        end
        if (m_valid && !m_ready) check("stall_s_ready", WB'(s_ready), WB'(0));
        if ((dut.f0_wr && dut.f0_full) || (dut.f0_rd && dut.f0_empty) ||
            (dut.f1_wr && dut.f1_full) || (dut.f1_rd && dut.f1_empty)) viol++;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_window: got %h while none expected", m_win);
          end else begin
            e = exp_q.pop_front();
            check("win", m_win, e.win);
            check("last", WB'(m_last), WB'(e.last));
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_win   = m_win;
        prev_last  = m_last;
      end
    end
  end

  initial begin
    int n;
    first_win = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", WB'(m_valid), WB'(0));
    check("rst_m_last", WB'(m_last), WB'(0));
    check("rst_m_win", m_win, WB'(0));
    check("rst_s_ready", WB'(s_ready), WB'(1));
    fifo_empty_chk("rst_fifos_empty");
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-pattern frame, then a second one back to back.
    send_range(1'b0, 0, 2 * IW + 3, 1'b0);
    first_window_chk();
    send_range(1'b0, 2 * IW + 3, NPIX, 1'b0);
    fifo_empty_chk("fifo_empty_frame_a");
    send_range(1'b0, 0, NPIX, 1'b0);
    fifo_empty_chk("fifo_empty_frame_b");

    // Downstream stall for 5 clocks after the first window.
    send_range(1'b1, 0, 2 * IW + 3, 1'b0);
    hold = 1;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 hold = 0;
      end
    join_none
    send_range(1'b1, 2 * IW + 3, NPIX, 1'b0);
    fifo_empty_chk("fifo_empty_stall");

    // Early SOF at pixel 6 forces a flush and restarts the frame.
    send_range(1'b1, 0, 6, 1'b0);
    send_pixel(W'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b1);
    send_range(1'b1, 1, NPIX, 1'b0);
    fifo_empty_chk("fifo_empty_sof");

    // Asynchronous reset in the middle of row 2 with a window pending.
    send_range(1'b1, 0, 2 * IW + 5, 1'b0);
    hold = 1;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_m_valid", WB'(m_valid), WB'(0));
    check("midrst_m_last", WB'(m_last), WB'(0));
    check("midrst_m_win", m_win, WB'(0));
    fifo_empty_chk("midrst_fifos_empty");
    exp_q.delete();
    mr = 0; mc = 0;
    hold = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send_range(1'b0, 0, 2 * IW + 3, 1'b0);
    first_window_chk();
    send_range(1'b0, 2 * IW + 3, NPIX, 1'b0);

    // Random input gaps and random downstream back-pressure.
    rnd_ready = 1;
    send_range(1'b1, 0, NPIX, 1'b1);
    send_range(1'b1, 0, NPIX, 1'b1);
    rnd_ready = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    check("drain_queue_empty", WB'(exp_q.size()), WB'(0));
    fifo_empty_chk("fifo_empty_final");
    check("fifo_protocol_violations", WB'(viol), WB'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
